// File: rtl/bus_arb2_if.sv
// Bundle of the two initiator ports and the single slave port of the req/gnt/hrd bus.
// Strobes are single-cycle requests; ready is the one-cycle completion, read data is valid only with it.
interface bus_arb2_if;
    logic        m0_req, m1_req;
    logic        m0_gnt, m1_gnt;
    logic        m0_hrd, m1_hrd;
    logic [31:0] m0_a, m1_a;
    logic [31:0] m0_d, m1_d;
    logic        m0_we, m1_we, m0_rd, m1_rd;
    logic [31:0] m0_spo, m1_spo;
    logic        m0_ready, m1_ready;
    logic [31:0] s_a, s_d;
    logic        s_we, s_rd;
    logic [31:0] s_spo;
    logic        s_ready;
    logic        buserr;

    // Arbiter view: it is the target of both initiators and drives the slave bus.
    modport slave (
        input  m0_req, m1_req, m0_a, m1_a, m0_d, m1_d,
        input  m0_we, m1_we, m0_rd, m1_rd, s_spo, s_ready,
        output m0_gnt, m1_gnt, m0_hrd, m1_hrd, m0_spo, m1_spo,
        output m0_ready, m1_ready, s_a, s_d, s_we, s_rd, buserr
    );

    modport master (
        output m0_req, m1_req, m0_a, m1_a, m0_d, m1_d,
        output m0_we, m1_we, m0_rd, m1_rd, s_spo, s_ready,
        input  m0_gnt, m1_gnt, m0_hrd, m1_hrd, m0_spo, m1_spo,
        input  m0_ready, m1_ready, s_a, s_d, s_we, s_rd, buserr
    );
endinterface

// File: rtl/bus_arb2.sv
// Two-initiator, one-slave arbiter: alternating tie-break, single outstanding transfer,
// combinational request/response paths and a watchdog that ends stalled transfers with buserr.
module bus_arb2 #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    bus_arb2_if.slave  bus,
    output logic [1:0] dbg_own_o,
    output logic       dbg_outst_o
);
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_M0   = 2'd1,
        OWN_M1   = 2'd2
    } own_e;

    localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

    own_e        own_q, own_d;
    logic        last_q, last_d;   // 1 = M1 was granted last
    logic        outst_q, outst_d;
    logic [15:0] wd_q, wd_d;

    logic gnt0, gnt1, we_raw, rd_raw, fwd_we, fwd_rd, fwd, fire, done;

    always_ff @(posedge clk) begin
        if (rst) begin
            own_q   <= OWN_NONE;
            last_q  <= 1'b1;
            outst_q <= 1'b0;
            wd_q    <= 16'd0;
        end else begin
            own_q   <= own_d;
            last_q  <= last_d;
            outst_q <= outst_d;
            wd_q    <= wd_d;
        end
    end

    always_comb begin
        own_d   = own_q;
        last_d  = last_q;
        outst_d = outst_q;
        wd_d    = wd_q;
        bus.s_a = 32'd0;
        bus.s_d = 32'd0;
        we_raw  = 1'b0;
        rd_raw  = 1'b0;

        gnt0 = (own_q == OWN_M0) && bus.m0_req;
        gnt1 = (own_q == OWN_M1) && bus.m1_req;
        if (gnt0) begin
            bus.s_a = bus.m0_a;
            bus.s_d = bus.m0_d;
            we_raw  = bus.m0_we;
            rd_raw  = bus.m0_rd;
        end else if (gnt1) begin
            bus.s_a = bus.m1_a;
            bus.s_d = bus.m1_d;
            we_raw  = bus.m1_we;
            rd_raw  = bus.m1_rd;
        end

        // A strobe while a transfer is still in flight is dropped, never queued.
        fwd_we = we_raw && !outst_q;
        fwd_rd = rd_raw && !outst_q;
        fwd    = fwd_we || fwd_rd;
        fire   = outst_q && !bus.s_ready && (wd_q == WD_LAST);
        done   = bus.s_ready && (outst_q || fwd);

        bus.s_we     = fwd_we;
        bus.s_rd     = fwd_rd;
        bus.buserr   = fire;
        bus.m0_gnt   = gnt0;
        bus.m1_gnt   = gnt1;
        bus.m0_hrd   = (own_q != OWN_NONE) && (own_q != OWN_M0);
        bus.m1_hrd   = (own_q != OWN_NONE) && (own_q != OWN_M1);
        bus.m0_ready = (own_q == OWN_M0) && (done || fire);
        bus.m1_ready = (own_q == OWN_M1) && (done || fire);
        bus.m0_spo   = ((own_q == OWN_M0) && !fire) ? bus.s_spo : 32'd0;
        bus.m1_spo   = ((own_q == OWN_M1) && !fire) ? bus.s_spo : 32'd0;

        if (outst_q) begin
            if (bus.s_ready || fire) outst_d = 1'b0;
            else wd_d = wd_q + 16'd1;
        end else if (fwd && !bus.s_ready) begin
            outst_d = 1'b1;
            wd_d    = 16'd0;
        end

        // Grants only leave NONE, which guarantees a dead cycle between owners.
        case (own_q)
            OWN_NONE: begin
                if (bus.m0_req && (!bus.m1_req || last_q)) begin
                    own_d  = OWN_M0;
                    last_d = 1'b0;
                end else if (bus.m1_req) begin
                    own_d  = OWN_M1;
                    last_d = 1'b1;
                end
            end
            OWN_M0:  if (!bus.m0_req && !outst_q) own_d = OWN_NONE;
            OWN_M1:  if (!bus.m1_req && !outst_q) own_d = OWN_NONE;
            default: own_d = OWN_NONE;
        endcase
    end

    assign dbg_own_o   = own_q;
    assign dbg_outst_o = outst_q;
endmodule

// File: tb/tb_bus_arb2.sv
// Scenario bench for bus_arb2: each task drives one scenario and checks inline; completions
// are matched against an expected queue of {master, buserr, spo}.
module tb_bus_arb2;
    localparam int unsigned TIMEOUT = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] dbg_own;
    logic       dbg_outst;

    always #5 clk = ~clk;

    bus_arb2_if bus ();

    bus_arb2 #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .bus(bus), .dbg_own_o(dbg_own), .dbg_outst_o(dbg_outst)
    );

    int checks = 0;
    int errors = 0;
    logic [33:0] exp_q[$];
    logic [33:0] exp_v, got_v;

    // Advance to just after the next rising edge; inputs change here.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Sample point for outputs of the current cycle.
    task automatic smp();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.m0_req = 0; bus.m1_req = 0; bus.m0_we = 0; bus.m1_we = 0;
        bus.m0_rd = 0; bus.m1_rd = 0; bus.m0_a = 0; bus.m1_a = 0;
        bus.m0_d = 0; bus.m1_d = 0; bus.s_spo = 0; bus.s_ready = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        bus.s_ready = 1;
        bus.s_spo = 32'hA5A5_5A5A;
        cyc(); cyc(); smp();
        checks++;
        if ({bus.m0_gnt, bus.m1_gnt, bus.m0_hrd, bus.m1_hrd, bus.s_we, bus.s_rd,
             bus.m0_ready, bus.m1_ready, bus.buserr, dbg_own, dbg_outst} !== 12'd0) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 0", {bus.m0_gnt, bus.m1_gnt, bus.m0_hrd,
                     bus.m1_hrd, bus.s_we, bus.s_rd, bus.m0_ready, bus.m1_ready, bus.buserr,
                     dbg_own, dbg_outst});
        end
        checks++;
        if ({bus.s_a, bus.s_d, bus.m0_spo, bus.m1_spo} !== 128'd0) begin
            errors++;
            $display("FAIL reset_data got %h want 0", {bus.s_a, bus.s_d, bus.m0_spo, bus.m1_spo});
        end
        cyc();
        rst = 0;
        idle_inputs();
    endtask

    task automatic test_tie();
        cyc(); bus.m0_req = 1; bus.m1_req = 1; smp();
        checks++;
        if ({bus.m0_gnt, bus.m1_gnt} !== 2'b00) begin
            errors++; $display("FAIL tie_latency got %b want 00", {bus.m0_gnt, bus.m1_gnt});
        end
        cyc(); smp();
        checks++;
        if ({bus.m0_gnt, bus.m1_gnt, bus.m0_hrd, bus.m1_hrd} !== 4'b1001) begin
            errors++;
            $display("FAIL tie_first got %b want 1001", {bus.m0_gnt, bus.m1_gnt, bus.m0_hrd, bus.m1_hrd});
        end
        cyc(); bus.m0_req = 0; smp();
        cyc(); smp();
        checks++;
        if ({dbg_own, bus.m0_gnt, bus.m1_gnt, bus.m1_hrd} !== 5'b00000) begin
            errors++;
            $display("FAIL tie_gap got %b want 00000", {dbg_own, bus.m0_gnt, bus.m1_gnt, bus.m1_hrd});
        end
        cyc(); smp();
        checks++;
        if ({bus.m0_gnt, bus.m1_gnt, bus.m0_hrd} !== 3'b011) begin
            errors++; $display("FAIL tie_handover got %b want 011", {bus.m0_gnt, bus.m1_gnt, bus.m0_hrd});
        end
        cyc(); bus.m1_req = 0; smp();
        cyc(); bus.m0_req = 1; bus.m1_req = 1; smp();
        cyc(); smp();
        checks++;
        if ({bus.m0_gnt, bus.m1_gnt} !== 2'b10) begin
            errors++; $display("FAIL tie_second got %b want 10", {bus.m0_gnt, bus.m1_gnt});
        end
        cyc(); bus.m0_req = 0; bus.m1_req = 0; smp();
        cyc(); bus.m0_req = 1; bus.m1_req = 1; smp();
        cyc(); smp();
        checks++;
        if ({bus.m0_gnt, bus.m1_gnt} !== 2'b01) begin
            errors++; $display("FAIL tie_third got %b want 01", {bus.m0_gnt, bus.m1_gnt});
        end
        cyc(); idle_inputs(); cyc(); cyc();
    endtask

    task automatic test_m0_read();
        cyc(); bus.m0_req = 1; bus.m0_a = 32'h8000_0010; smp();
        cyc(); smp();
        checks++;
        if ({bus.m0_gnt, bus.m0_hrd, bus.m1_hrd} !== 3'b101) begin
            errors++; $display("FAIL rd_gnt got %b want 101", {bus.m0_gnt, bus.m0_hrd, bus.m1_hrd});
        end
        cyc(); bus.m0_rd = 1; exp_q.push_back({1'b0, 1'b0, 32'hDEAD_BEEF}); smp();
        checks++;
        if ({bus.s_rd, bus.s_we, bus.m0_ready, bus.s_a} !== {3'b100, 32'h8000_0010}) begin
            errors++;
            $display("FAIL rd_strobe got %b %h want 100 80000010", {bus.s_rd, bus.s_we, bus.m0_ready}, bus.s_a);
        end
        for (int k = 1; k <= 3; k++) begin
            cyc();
            bus.m0_rd = 0;
            bus.s_spo = $urandom;
            if (k == 3) begin
                bus.s_ready = 1;
                bus.s_spo = 32'hDEAD_BEEF;
            end
            smp();
            checks++;
            if (k < 3) begin
                if ({bus.s_rd, bus.m0_ready, bus.m1_hrd, dbg_outst} !== 4'b0011) begin
                    errors++;
                    $display("FAIL rd_wait%0d got %b want 0011", k, {bus.s_rd, bus.m0_ready, bus.m1_hrd, dbg_outst});
                end
            end else if (bus.m0_ready !== 1'b1 || exp_q.size() == 0) begin
                errors++; $display("FAIL rd_resp got ready %b want 1", bus.m0_ready);
            end else begin
                exp_v = exp_q.pop_front();
                got_v = {1'b0, bus.buserr, bus.m0_spo};
                if (got_v !== exp_v) begin
                    errors++; $display("FAIL rd_data got %h want %h", got_v, exp_v);
                end
            end
        end
        cyc(); bus.s_ready = 0; bus.m0_req = 0; smp();
        checks++;
        if ({bus.m0_ready, dbg_outst} !== 2'b00) begin
            errors++; $display("FAIL rd_after got %b want 00", {bus.m0_ready, dbg_outst});
        end
        cyc(); smp();
        checks++;
        if ({dbg_own, bus.m1_hrd} !== 3'b000) begin
            errors++; $display("FAIL rd_release got %b want 000", {dbg_own, bus.m1_hrd});
        end
        idle_inputs();
    endtask

    task automatic test_zero_wait_write();
        cyc(); bus.m1_req = 1; smp();
        cyc(); smp();
        cyc();
        bus.m1_we = 1; bus.m1_a = 32'h0000_0F00; bus.m1_d = 32'h1357_9BDF;
        bus.s_ready = 1; bus.s_spo = 32'hCAFE_0001;
        exp_q.push_back({1'b1, 1'b0, 32'hCAFE_0001});
        smp();
        checks++;
        if ({bus.s_we, bus.s_rd, bus.m0_hrd, bus.s_a, bus.s_d} !== {3'b101, 32'h0000_0F00, 32'h1357_9BDF}) begin
            errors++;
            $display("FAIL wr_fwd got %b %h %h want 101 00000f00 13579bdf", {bus.s_we, bus.s_rd, bus.m0_hrd}, bus.s_a, bus.s_d);
        end
        checks++;
        if (bus.m1_ready !== 1'b1 || exp_q.size() == 0) begin
            errors++; $display("FAIL wr_resp got ready %b want 1", bus.m1_ready);
        end else begin
            exp_v = exp_q.pop_front();
            got_v = {1'b1, bus.buserr, bus.m1_spo};
            if (got_v !== exp_v) begin
                errors++; $display("FAIL wr_data got %h want %h", got_v, exp_v);
            end
        end
        cyc(); bus.m1_we = 0; bus.s_ready = 0; bus.m1_req = 0; smp();
        checks++;
        if ({dbg_outst, bus.m1_ready, bus.s_we} !== 3'b000) begin
            errors++; $display("FAIL wr_after got %b want 000", {dbg_outst, bus.m1_ready, bus.s_we});
        end
        cyc(); smp();
        checks++;
        if (dbg_own !== 2'd0) begin
            errors++; $display("FAIL wr_release got %0d want 0", dbg_own);
        end
        idle_inputs();
    endtask

    task automatic test_hold();
        cyc(); bus.m0_req = 1; bus.m0_a = 32'h0000_2000; smp();
        cyc(); smp();
        cyc(); bus.m1_req = 1; bus.m0_rd = 1; exp_q.push_back({1'b0, 1'b0, 32'h0BAD_F00D}); smp();
        checks++;
        if ({bus.s_rd, bus.m1_hrd, bus.m1_gnt} !== 3'b110) begin
            errors++; $display("FAIL hold_strobe got %b want 110", {bus.s_rd, bus.m1_hrd, bus.m1_gnt});
        end
        for (int k = 0; k < 2; k++) begin
            cyc(); bus.m0_rd = 0; bus.m0_req = 0; smp();
            checks++;
            if ({dbg_own, dbg_outst, bus.m1_hrd, bus.m0_gnt} !== 5'b01110) begin
                errors++;
                $display("FAIL hold_kept%0d got %b want 01110", k, {dbg_own, dbg_outst, bus.m1_hrd, bus.m0_gnt});
            end
        end
        cyc(); bus.s_ready = 1; bus.s_spo = 32'h0BAD_F00D; smp();
        checks++;
        if (bus.m0_ready !== 1'b1 || exp_q.size() == 0) begin
            errors++; $display("FAIL hold_resp got ready %b want 1", bus.m0_ready);
        end else begin
            exp_v = exp_q.pop_front();
            got_v = {1'b0, bus.buserr, bus.m0_spo};
            if (got_v !== exp_v) begin
                errors++; $display("FAIL hold_data got %h want %h", got_v, exp_v);
            end
        end
        cyc(); bus.s_ready = 0; smp();
        checks++;
        if ({dbg_own, bus.m1_hrd, dbg_outst} !== 4'b0110) begin
            errors++; $display("FAIL hold_post got %b want 0110", {dbg_own, bus.m1_hrd, dbg_outst});
        end
        cyc(); smp();
        checks++;
        if ({dbg_own, bus.m1_hrd, bus.m1_gnt} !== 4'b0000) begin
            errors++; $display("FAIL hold_free got %b want 0000", {dbg_own, bus.m1_hrd, bus.m1_gnt});
        end
        cyc(); smp();
        checks++;
        if ({bus.m1_gnt, bus.m0_hrd} !== 2'b11) begin
            errors++; $display("FAIL hold_next got %b want 11", {bus.m1_gnt, bus.m0_hrd});
        end
        cyc(); idle_inputs(); cyc(); cyc();
    endtask

    task automatic test_timeout();
        cyc(); bus.m0_req = 1; bus.m0_a = 32'h9000_0000; smp();
        cyc(); smp();
        cyc(); bus.m0_rd = 1; exp_q.push_back({1'b0, 1'b1, 32'd0}); smp();
        checks++;
        if (bus.s_rd !== 1'b1) begin
            errors++; $display("FAIL to_strobe got %b want 1", bus.s_rd);
        end
        for (int k = 1; k < int'(TIMEOUT); k++) begin
            cyc();
            bus.m0_rd = 0;
            bus.m0_we = (k == 2);
            bus.s_spo = $urandom;
            smp();
            checks++;
            if ({bus.s_we, bus.s_rd, bus.m0_ready, bus.buserr, dbg_outst} !== 5'b00001) begin
                errors++;
                $display("FAIL to_wait%0d got %b want 00001", k, {bus.s_we, bus.s_rd, bus.m0_ready, bus.buserr, dbg_outst});
            end
        end
        cyc(); bus.m0_we = 0; bus.s_spo = 32'hFFFF_FFFF; smp();
        checks++;
        if (bus.m0_ready !== 1'b1 || exp_q.size() == 0) begin
            errors++; $display("FAIL to_fire got ready %b want 1", bus.m0_ready);
        end else begin
            exp_v = exp_q.pop_front();
            got_v = {1'b0, bus.buserr, bus.m0_spo};
            if (got_v !== exp_v) begin
                errors++; $display("FAIL to_data got %h want %h", got_v, exp_v);
            end
        end
        cyc(); smp();
        checks++;
        if ({bus.m0_ready, bus.buserr, dbg_outst} !== 3'b000) begin
            errors++; $display("FAIL to_pulse got %b want 000", {bus.m0_ready, bus.buserr, dbg_outst});
        end
        cyc(); bus.s_ready = 1; bus.s_spo = 32'h7777_7777; smp();
        checks++;
        if ({bus.m0_ready, bus.m1_ready, bus.buserr} !== 3'b000) begin
            errors++; $display("FAIL to_late got %b want 000", {bus.m0_ready, bus.m1_ready, bus.buserr});
        end
        cyc(); idle_inputs(); cyc(); cyc();
    endtask

    task automatic test_timeout_race();
        cyc(); bus.m1_req = 1; bus.m1_a = 32'h0000_0040; smp();
        cyc(); smp();
        cyc(); bus.m1_rd = 1; exp_q.push_back({1'b1, 1'b0, 32'h1234_5678}); smp();
        for (int k = 1; k < int'(TIMEOUT); k++) begin
            cyc(); bus.m1_rd = 0; smp();
        end
        cyc(); bus.s_ready = 1; bus.s_spo = 32'h1234_5678; smp();
        checks++;
        if (bus.m1_ready !== 1'b1 || exp_q.size() == 0) begin
            errors++; $display("FAIL race_resp got ready %b want 1", bus.m1_ready);
        end else begin
            exp_v = exp_q.pop_front();
            got_v = {1'b1, bus.buserr, bus.m1_spo};
            if (got_v !== exp_v) begin
                errors++; $display("FAIL race_data got %h want %h", got_v, exp_v);
            end
        end
        cyc(); bus.s_ready = 0; bus.m1_req = 0; smp();
        checks++;
        if ({dbg_outst, bus.buserr} !== 2'b00) begin
            errors++; $display("FAIL race_after got %b want 00", {dbg_outst, bus.buserr});
        end
        cyc(); idle_inputs(); cyc();
    endtask

    task automatic test_reset_mid();
        cyc(); bus.m1_req = 1; bus.m1_a = 32'h0000_0400; smp();
        cyc(); smp();
        cyc(); bus.m1_rd = 1; smp();
        cyc(); bus.m1_rd = 0; smp();
        checks++;
        if (dbg_outst !== 1'b1) begin
            errors++; $display("FAIL rstmid_outst got %b want 1", dbg_outst);
        end
        cyc(); rst = 1; smp();
        cyc(); rst = 0; bus.m1_req = 0; bus.m0_req = 1; bus.s_spo = 32'h5555_AAAA; smp();
        checks++;
        if ({bus.m0_gnt, bus.m1_gnt, bus.m0_hrd, bus.m1_hrd, bus.s_we, bus.s_rd, bus.m0_ready,
             bus.m1_ready, bus.buserr, dbg_own, dbg_outst, bus.s_a, bus.m0_spo, bus.m1_spo} !== 108'd0) begin
            errors++;
            $display("FAIL rstmid_clear got %b %h %h %h want 0", {bus.m0_gnt, bus.m1_gnt, bus.m0_hrd,
                     bus.m1_hrd, bus.s_we, bus.s_rd, bus.m0_ready, bus.m1_ready, bus.buserr, dbg_own,
                     dbg_outst}, bus.s_a, bus.m0_spo, bus.m1_spo);
        end
        cyc(); bus.s_ready = 1; smp();
        checks++;
        if ({bus.m0_gnt, bus.m0_ready, bus.m1_hrd} !== 3'b101) begin
            errors++; $display("FAIL rstmid_regrant got %b want 101", {bus.m0_gnt, bus.m0_ready, bus.m1_hrd});
        end
        cyc(); idle_inputs(); cyc(); cyc();
    endtask

    initial begin
        test_reset();
        test_tie();
        test_m0_read();
        test_zero_wait_write();
        test_hold();
        test_timeout();
        test_timeout_race();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL sb_drain got %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
